// File: rtl/bcd_pkg.sv
// Shared BCD constants, digit type, converter state encoding and a width helper
// used by both the BCD-to-binary and binary-to-BCD paths.
package bcd_pkg;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_ADJ_THRESH = 8;
  localparam int BCD_ADJ_SUB    = 3;
  localparam int BCD_ADD_THRESH = 5;
  localparam int BCD_ADD_VAL    = 3;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Smallest binary width able to hold 10^digits - 1, i.e. ceil(log2(10^digits)).
  function automatic int bcd_min_bin_w(input int digits);
    longint unsigned p;
    int w;
    p = 64'd1;
    w = 0;
    for (int i = 0; i < 19; i++) begin
      if (i < digits) p = p * 64'd10;
    end
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < p) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when the
// post-shift nibble is 8 or more.
module bcd_nibble_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t nib_i,
  output bcd_digit_t nib_o
);

  assign nib_o = (nib_i >= bcd_digit_t'(BCD_ADJ_THRESH))
               ? nib_i - bcd_digit_t'(BCD_ADJ_SUB)
               : nib_i;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double dabble, one bit per
// cycle). Define BCD2BIN_CHECK_EN to flag digits above 9 on err and zero the result.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          err
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (BIN_W < bcd_min_bin_w(DIGITS)) begin : g_bin_w_too_small
    $error("bcd2bin_seq: BIN_W too small for DIGITS");
  end

  conv_state_t           state_q, state_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [BIN_W-1:0]      bin_out_q, bin_out_d;

  logic [BCD_W+BIN_W-1:0] sh_s;
  logic [BCD_W-1:0]       bcd_sh_s;
  logic [BCD_W-1:0]       bcd_adj_s;
  logic [BIN_W-1:0]       bin_sh_s;

  assign sh_s     = {bcd_q, bin_q} >> 1;
  assign bcd_sh_s = sh_s[BCD_W+BIN_W-1:BIN_W];
  assign bin_sh_s = sh_s[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_nibble_adj u_adj (
      .nib_i (bcd_sh_s[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .nib_o (bcd_adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD2BIN_CHECK_EN
  logic inv_q, inv_d;
  logic err_q, err_d;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // State register and datapath flops; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bin_out_q   <= '0;
`ifdef BCD2BIN_CHECK_EN
      inv_q       <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      bin_out_q   <= bin_out_d;
`ifdef BCD2BIN_CHECK_EN
      inv_q       <= inv_d;
      err_q       <= err_d;
`endif
    end
  end

  // Next-state logic; handshake outputs are precomputed so they come straight from flops.
  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    bin_out_d   = bin_out_q;
`ifdef BCD2BIN_CHECK_EN
    inv_d       = inv_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          bcd_d      = bcd_in;
          bin_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          in_ready_d = 1'b0;
          state_d    = SHIFT;
`ifdef BCD2BIN_CHECK_EN
          inv_d      = has_bad_digit(bcd_in);
`endif
        end else begin
          in_ready_d = 1'b1;
        end
      end
      SHIFT: begin
        bcd_d = bcd_adj_s;
        bin_d = bin_sh_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
`ifdef BCD2BIN_CHECK_EN
          bin_out_d   = inv_q ? '0 : bin_sh_s;
          err_d       = inv_q;
`else
          bin_out_d   = bin_sh_s;
`endif
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
`ifdef BCD2BIN_CHECK_EN
          inv_d       = 1'b0;
          err_d       = 1'b0;
`endif
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_out   = bin_out_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: 2-digit and 3-digit instances, table
// vectors, handshake/reset corner sequences and randomized model comparison.
module tb_bcd2bin_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv2 = 1'b0, or2 = 1'b0;
  logic [7:0] bcd2 = 8'h00;
  logic       ir2, ov2, err2;
  logic [6:0] bin2;

  logic        iv3 = 1'b0, or3 = 1'b0;
  logic [11:0] bcd3 = 12'h000;
  logic        ir3, ov3, err3;
  logic [9:0]  bin3;

  bcd2bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .bcd_in(bcd2),
    .out_valid(ov2), .out_ready(or2), .bin_out(bin2), .err(err2)
  );

  bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .bcd_in(bcd3),
    .out_valid(ov3), .out_ready(or3), .bin_out(bin3), .err(err3)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input bit w3);
    return w3 ? ir3 : ir2;
  endfunction
  function automatic logic ovf(input bit w3);
    return w3 ? ov3 : ov2;
  endfunction
  function automatic logic [9:0] bo(input bit w3);
    return w3 ? bin3 : {3'd0, bin2};
  endfunction
  function automatic logic erf(input bit w3);
    return w3 ? err3 : err2;
  endfunction

  task automatic drive(input bit w3, input logic v, input logic [11:0] b);
    if (w3) begin iv3 = v; bcd3 = b; end
    else begin iv2 = v; bcd2 = b[7:0]; end
  endtask

  task automatic set_or(input bit w3, input logic v);
    if (w3) or3 = v;
    else or2 = v;
  endtask

  // Reference: decimal value of the packed BCD digits, plus a bad-digit flag.
  function automatic void model(input logic [11:0] b, input int nd, output int v, output bit bad);
    int pw;
    logic [3:0] d;
    v = 0; bad = 1'b0; pw = 1;
    for (int i = 0; i < nd; i++) begin
      d = b[i*4 +: 4];
      if (d > 4'd9) bad = 1'b1;
      v = v + int'(d) * pw;
      pw = pw * 10;
    end
  endfunction

  // One full transaction; holds out_ready low for `hold` cycles of DONE.
  task automatic conv(input bit w3, input logic [11:0] b, input int hold,
                      output logic [9:0] res, output logic e, output int acc);
    int n;
    bit busy_rdy;
    logic [9:0] b0;
    n = 0;
    while (!rdy(w3) && n < 50) begin @(posedge clk); #1; n++; end
    check("accept_ready", 32'(rdy(w3)), 32'd1);
    drive(w3, 1'b1, b);
    @(posedge clk); #1;
    acc = cyc;
    drive(w3, 1'b0, 12'h000);
    busy_rdy = 1'b0;
    n = 0;
    while (!ovf(w3) && n < 50) begin
      if (rdy(w3)) busy_rdy = 1'b1;
      @(posedge clk); #1; n++;
    end
    check("latency", 32'(n), w3 ? 32'd10 : 32'd7);
    check("in_ready_busy", 32'(busy_rdy), 32'd0);
    check("in_ready_done", 32'(rdy(w3)), 32'd0);
    b0 = bo(w3);
    e  = erf(w3);
    for (int h = 0; h < hold; h++) begin
      drive(w3, 1'b1, 12'h777);
      @(posedge clk); #1;
      check("hold_valid", 32'(ovf(w3)), 32'd1);
      check("hold_bin", 32'(bo(w3)), 32'(b0));
      check("hold_ready", 32'(rdy(w3)), 32'd0);
    end
    drive(w3, 1'b0, 12'h000);
    set_or(w3, 1'b1);
    @(posedge clk); #1;
    set_or(w3, 1'b0);
    check("consumed_valid", 32'(ovf(w3)), 32'd0);
    check("idle_ready", 32'(rdy(w3)), 32'd1);
    res = b0;
  endtask

  typedef struct {
    logic [7:0] bcd;
    logic [6:0] bin;
    int         hold;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [9:0] r;
    logic e;
    int a0, a1, v, n;
    bit bad;
    logic [11:0] rb;

    tbl[0] = '{8'h59, 7'd59, 0};
    tbl[1] = '{8'h00, 7'd0,  0};
    tbl[2] = '{8'h99, 7'd99, 1};
    tbl[3] = '{8'h23, 7'd23, 10};
    tbl[4] = '{8'h10, 7'd10, 2};
    tbl[5] = '{8'h01, 7'd1,  0};
    tbl[6] = '{8'h90, 7'd90, 3};
    tbl[7] = '{8'h47, 7'd47, 0};

    #12;
    check("rst_in_ready", 32'(ir2), 32'd1);
    check("rst_out_valid", 32'(ov2), 32'd0);
    check("rst_bin_out", 32'(bin2), 32'd0);
    check("rst_err", 32'(err2), 32'd0);
    check("rst3_in_ready", 32'(ir3), 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      conv(1'b0, {4'h0, tbl[i].bcd}, tbl[i].hold, r, e, a0);
      check("tbl_bin", 32'(r), 32'(tbl[i].bin));
      check("tbl_err", 32'(e), 32'd0);
    end

    // Back-to-back: second accept is BIN_W+2 cycles after the first.
    conv(1'b0, 12'h000, 0, r, e, a0);
    check("b2b_first", 32'(r), 32'd0);
    conv(1'b0, 12'h099, 0, r, e, a1);
    check("b2b_second", 32'(r), 32'd99);
    check("b2b_period", 32'(a1 - a0), 32'd9);

    // Reset during SHIFT (after iteration 3).
    drive(1'b0, 1'b1, 12'h047);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 12'h000);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; #1;
    check("abort_shift_ready", 32'(ir2), 32'd1);
    check("abort_shift_valid", 32'(ov2), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    conv(1'b0, 12'h012, 0, r, e, a0);
    check("after_abort_bin", 32'(r), 32'd12);

    // Reset while a result is waiting in DONE.
    drive(1'b0, 1'b1, 12'h036);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 12'h000);
    n = 0;
    while (!ov2 && n < 50) begin @(posedge clk); #1; n++; end
    check("done_reached", 32'(ov2), 32'd1);
    check("done_bin", 32'(bin2), 32'd36);
    #2; rst = 1'b1; #1;
    check("abort_done_valid", 32'(ov2), 32'd0);
    check("abort_done_ready", 32'(ir2), 32'd1);
    check("abort_done_bin", 32'(bin2), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

`ifdef BCD2BIN_CHECK_EN
    conv(1'b0, 12'h05A, 0, r, e, a0);
    check("inv_err", 32'(e), 32'd1);
    check("inv_bin", 32'(r), 32'd0);
    check("inv_err_cleared", 32'(err2), 32'd0);
    conv(1'b0, 12'h031, 0, r, e, a0);
    check("post_inv_err", 32'(e), 32'd0);
    check("post_inv_bin", 32'(r), 32'd31);
`endif

    conv(1'b1, 12'h999, 0, r, e, a0);
    check("d3_999", 32'(r), 32'd999);
    conv(1'b1, 12'h100, 2, r, e, a0);
    check("d3_100", 32'(r), 32'd100);

    for (int k = 0; k < 60; k++) begin
      bit w3;
      int nd;
      w3 = (k % 3) == 2;
      nd = w3 ? 3 : 2;
      rb = 12'h000;
      for (int d = 0; d < nd; d++) rb[d*4 +: 4] = 4'($urandom_range(9, 0));
`ifdef BCD2BIN_CHECK_EN
      if ($urandom_range(4, 0) == 0) rb[$urandom_range(nd - 1, 0)*4 +: 4] = 4'($urandom_range(15, 10));
`endif
      model(rb, nd, v, bad);
      conv(w3, rb, int'($urandom_range(2, 0)), r, e, a0);
      check("rand_err", 32'(e), 32'(bad));
      check("rand_bin", 32'(r), bad ? 32'd0 : 32'(v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
